// File: rtl/cp_pkg.sv
// Shared definitions for the cp memory stage: func3 encodings, FSM state enum,
// bus/writeback payload structs and a small access-size helper.
package cp_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;
  localparam int unsigned RA_W = 5;

  // Load / store func3 encodings; func3[1:0] is the size, func3[2] the unsigned flag
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    OUT  = 2'd3
  } mem_state_e;

  // Outstanding data-bus request
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic            we;
  } dmem_req_t;

  // Writeback result
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [RA_W-1:0] rd_addr;
    logic            we;
    logic            err;
  } wb_res_t;

  // Halfword with odd address, or word (size 10/11) with a nonzero offset
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/cp_lsu_align.sv
// Byte-lane alignment for the memory stage (combinational).
//   st_size_i/st_off_i/st_data_i/st_is_load_i -> be_o, wdata_o (request side)
//   ld_f3_i/ld_off_i/rdata_i                  -> ld_data_o     (response side)
// Low offset bits that do not apply to the access size are ignored, which
// masks misaligned halfword/word addresses.
module cp_lsu_align
  import cp_pkg::*;
(
  input  logic [1:0]      st_size_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic            st_is_load_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [2:0]      ld_f3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Loads read the whole word; stores enable only the addressed lanes
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    if (!st_is_load_i) begin
      case (st_size_i)
        2'b00: begin
          be_o    = 4'b0001 << st_off_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << {st_off_i[1], 1'b0};
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane extraction then sign/zero extension
  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_f3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data_o = {24'd0, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data_o = {16'd0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cp_mem_stage.sv
// Pipeline MEM stage: passes ALU results through, performs loads/stores on a
// req/gnt + rvalid data bus with a timeout, and presents a held WB result.
// Ports: clk, rst_n; EX side valid_ex_i/ready_ex_o + op fields; dmem_* bus;
// WB side valid_wb_o/ready_wb_i, rd_data/rd_addr/rd_we/err.
// Build option: CP_MEM_MISALIGN_EN faults misaligned halfword/word accesses
// without touching the bus; otherwise offending address bits are masked.
// TIMEOUT_CYC must be at least 1.
module cp_mem_stage
  import cp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_ex_i,
  output logic            ready_ex_o,
  input  logic [XLEN-1:0] alu_rs_ex_i,
  input  logic [XLEN-1:0] rs2_data_ex_i,
  input  logic [RA_W-1:0] rd_addr_ex_i,
  input  logic            rd_we_ex_i,
  input  logic            dmem_re_ex_i,
  input  logic            dmem_we_ex_i,
  input  logic [2:0]      func3_ex_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [BE_W-1:0] dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            valid_wb_o,
  input  logic            ready_wb_i,
  output logic [XLEN-1:0] rd_data_wb_o,
  output logic [RA_W-1:0] rd_addr_wb_o,
  output logic            rd_we_wb_o,
  output logic            err_wb_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rdy_en_q;
  logic            req_q, req_d;
  dmem_req_t       bus_q, bus_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            pend_we_q, pend_we_d;
  logic            valid_q, valid_d;
  wb_res_t         wb_q, wb_d;

  logic            accept;
  logic            is_st, is_ld, is_mem, mis;
  logic            timeout;
  logic [BE_W-1:0] al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ld_data;

  // Both re and we set counts as a store
  assign is_st  = dmem_we_ex_i;
  assign is_ld  = dmem_re_ex_i & ~dmem_we_ex_i;
  assign is_mem = is_st | is_ld;

`ifdef CP_MEM_MISALIGN_EN
  assign mis = misaligned(func3_ex_i[1:0], alu_rs_ex_i[1:0]);
`else
  assign mis = 1'b0;
`endif

  // rdy_en_q keeps ready low until the first clock edge after reset release
  assign ready_ex_o = rdy_en_q & ((state_q == IDLE) | ((state_q == OUT) & ready_wb_i));
  assign accept     = valid_ex_i & ready_ex_o;
  assign timeout    = (cnt_q == CNT_LAST);

  cp_lsu_align u_align (
    .st_size_i    (func3_ex_i[1:0]),
    .st_off_i     (alu_rs_ex_i[1:0]),
    .st_data_i    (rs2_data_ex_i),
    .st_is_load_i (is_ld),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .ld_f3_i      (f3_q),
    .ld_off_i     (off_q),
    .rdata_i      (dmem_rdata_i),
    .ld_data_o    (al_ld_data)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    bus_d     = bus_q;
    off_d     = off_q;
    f3_d      = f3_q;
    pend_we_d = pend_we_q;
    valid_d   = valid_q;
    wb_d      = wb_q;

    unique case (state_q)
      IDLE: ;
      REQ: begin
        if (dmem_gnt_i) begin
          req_d    = 1'b0;
          bus_d.we = 1'b0;
          if (bus_q.we) begin
            // Stores complete on grant; nothing to write back
            state_d = OUT;
            valid_d = 1'b1;
            wb_d.we = 1'b0;
            wb_d.err = 1'b0;
          end else begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          state_d  = OUT;
          req_d    = 1'b0;
          bus_d.we = 1'b0;
          valid_d  = 1'b1;
          wb_d.we  = 1'b0;
          wb_d.err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          state_d   = OUT;
          valid_d   = 1'b1;
          wb_d.data = al_ld_data;
          wb_d.we   = pend_we_q;
          wb_d.err  = 1'b0;
        end else if (timeout) begin
          state_d  = OUT;
          valid_d  = 1'b1;
          wb_d.we  = 1'b0;
          wb_d.err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        if (ready_wb_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New op from EX (IDLE, or OUT being drained this cycle)
    if (accept) begin
      wb_d = '{data: '0, rd_addr: rd_addr_ex_i, we: 1'b0, err: 1'b0};
      if (is_mem && mis) begin
        state_d  = OUT;
        valid_d  = 1'b1;
        wb_d.err = 1'b1;
      end else if (is_mem) begin
        state_d   = REQ;
        valid_d   = 1'b0;
        cnt_d     = '0;
        req_d     = 1'b1;
        bus_d     = '{addr: {alu_rs_ex_i[31:2], 2'b00}, be: al_be, wdata: al_wdata, we: is_st};
        off_d     = alu_rs_ex_i[1:0];
        f3_d      = func3_ex_i;
        pend_we_d = rd_we_ex_i & is_ld;
      end else begin
        state_d   = OUT;
        valid_d   = 1'b1;
        wb_d.data = alu_rs_ex_i;
        wb_d.we   = rd_we_ex_i;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_en_q  <= 1'b0;
      req_q     <= 1'b0;
      bus_q     <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      pend_we_q <= 1'b0;
      valid_q   <= 1'b0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdy_en_q  <= 1'b1;
      req_q     <= req_d;
      bus_q     <= bus_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      pend_we_q <= pend_we_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = bus_q.we;
  assign dmem_addr_o  = bus_q.addr;
  assign dmem_be_o    = bus_q.be;
  assign dmem_wdata_o = bus_q.wdata;
  assign valid_wb_o   = valid_q;
  assign rd_data_wb_o = wb_q.data;
  assign rd_addr_wb_o = wb_q.rd_addr;
  assign rd_we_wb_o   = wb_q.we;
  assign err_wb_o     = wb_q.err;

endmodule

// File: tb/tb_cp_mem_stage.sv
// Self-checking bench for cp_mem_stage. Inputs change and outputs are sampled
// on the falling edge; expected WB results are queued when an op is driven.
module tb_cp_mem_stage;
  import cp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex_i, ready_ex_o;
  logic [31:0] alu_rs_ex_i, rs2_data_ex_i;
  logic [4:0]  rd_addr_ex_i;
  logic        rd_we_ex_i, dmem_re_ex_i, dmem_we_ex_i;
  logic [2:0]  func3_ex_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_wb_o, ready_wb_i;
  logic [31:0] rd_data_wb_o;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_we_wb_o, err_wb_o;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    bit          chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int errors = 0;
  int checks = 0;

  cp_mem_stage #(.TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_ex_i(valid_ex_i), .ready_ex_o(ready_ex_o),
    .alu_rs_ex_i(alu_rs_ex_i), .rs2_data_ex_i(rs2_data_ex_i),
    .rd_addr_ex_i(rd_addr_ex_i), .rd_we_ex_i(rd_we_ex_i),
    .dmem_re_ex_i(dmem_re_ex_i), .dmem_we_ex_i(dmem_we_ex_i), .func3_ex_i(func3_ex_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
    .rd_data_wb_o(rd_data_wb_o), .rd_addr_wb_o(rd_addr_wb_o),
    .rd_we_wb_o(rd_we_wb_o), .err_wb_o(err_wb_o)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rwe, input logic re, input logic we, input logic [2:0] f3);
    valid_ex_i = 1'b1; alu_rs_ex_i = alu; rs2_data_ex_i = rs2; rd_addr_ex_i = rd;
    rd_we_ex_i = rwe; dmem_re_ex_i = re; dmem_we_ex_i = we; func3_ex_i = f3;
  endtask

  task automatic clear_ex();
    valid_ex_i = 1'b0; rd_we_ex_i = 1'b0; dmem_re_ex_i = 1'b0; dmem_we_ex_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_ex(); alu_rs_ex_i = '0; rs2_data_ex_i = '0; rd_addr_ex_i = '0; func3_ex_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; ready_wb_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ready_ex_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, valid_wb_o,
                  rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, err_wb_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero in reset, req=%b valid=%b ready=%b", dmem_req_o, valid_wb_o, ready_ex_o);
    end
    rst_n = 1'b1; #1;
    checks++; if (ready_ex_o !== 1'b0) begin errors++; $display("FAIL reset_ready_pre_edge got=%b exp=0", ready_ex_o); end
    @(negedge clk);
    checks++; if (ready_ex_o !== 1'b1) begin errors++; $display("FAIL reset_ready_post_edge got=%b exp=1", ready_ex_o); end
  endtask

  task automatic test_nonmem();
    wb_exp_t e;
    drive_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, F3_LW);
    sb.push_back('{32'h1234, 5'd5, 1'b1, 1'b0, 1'b1});
    @(negedge clk); clear_ex();
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL nonmem_req got=%b exp=0", dmem_req_o); end
    e = sb.pop_front();
    checks++; if (valid_wb_o !== 1'b1 || rd_data_wb_o !== e.data || rd_addr_wb_o !== e.rd || rd_we_wb_o !== e.we || err_wb_o !== e.err) begin
      errors++; $display("FAIL nonmem_wb got v=%b d=%h rd=%0d we=%b err=%b exp d=%h rd=%0d we=%b err=%b",
                         valid_wb_o, rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, err_wb_o, e.data, e.rd, e.we, e.err);
    end
    @(negedge clk);
    checks++; if (valid_wb_o !== 1'b0) begin errors++; $display("FAIL nonmem_idle valid got=%b exp=0", valid_wb_o); end
  endtask

  task automatic test_load();
`ifdef CP_MEM_MISALIGN_EN
    localparam int N = 6;
`else
    localparam int N = 8;
`endif
    logic [31:0] a_t[8] = '{32'h103, 32'h103, 32'h202, 32'h200, 32'h100, 32'h101, 32'h203, 32'h302};
    logic [2:0]  f_t[8] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LH, F3_LW};
    logic [31:0] r_t[8] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h8001_1234, 32'h8001_1234,
                            32'hDEAD_BEEF, 32'h0000_7F00, 32'h8001_1234, 32'hCAFE_0001};
    logic [31:0] x_t[8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_1234,
                            32'hDEAD_BEEF, 32'h0000_007F, 32'hFFFF_8001, 32'hCAFE_0001};
    wb_exp_t e;
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      a = a_t[i];
      drive_op(a, 32'h0, 5'(10 + i), 1'b1, 1'b1, 1'b0, f_t[i]);
      sb.push_back('{x_t[i], 5'(10 + i), 1'b1, 1'b0, 1'b1});
      @(negedge clk); clear_ex();
      checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== {a[31:2], 2'b00} || dmem_be_o !== 4'b1111) begin
        errors++; $display("FAIL load%0d_req got req=%b we=%b addr=%h be=%b exp req=1 we=0 addr=%h be=1111",
                           i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, {a[31:2], 2'b00});
      end
      dmem_gnt_i = 1'b1;
      @(negedge clk); dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = r_t[i];
      @(negedge clk); dmem_rvalid_i = 1'b0;
      e = sb.pop_front();
      checks++; if (valid_wb_o !== 1'b1 || rd_data_wb_o !== e.data || rd_addr_wb_o !== e.rd || rd_we_wb_o !== e.we || err_wb_o !== e.err) begin
        errors++; $display("FAIL load%0d_wb got v=%b d=%h rd=%0d we=%b err=%b exp d=%h rd=%0d we=%b err=%b",
                           i, valid_wb_o, rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, err_wb_o, e.data, e.rd, e.we, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
`ifdef CP_MEM_MISALIGN_EN
    localparam int N = 3;
`else
    localparam int N = 5;
`endif
    logic [31:0] a_t[5] = '{32'h202, 32'h101, 32'h300, 32'h203, 32'h302};
    logic [2:0]  f_t[5] = '{F3_SH, F3_SB, F3_SW, F3_SH, F3_SW};
    logic [31:0] d_t[5] = '{32'h1234_ABCD, 32'h0000_005A, 32'h1234_5678, 32'h1234_ABCD, 32'h8765_4321};
    logic [3:0]  b_t[5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1100, 4'b1111};
    logic [31:0] w_t[5] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1234_5678, 32'hABCD_ABCD, 32'h8765_4321};
    wb_exp_t e;
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      a = a_t[i];
      // entry 2 also sets the load flag; it must still be a store
      drive_op(a, d_t[i], 5'd3, 1'b1, (i == 2), 1'b1, f_t[i]);
      sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
      @(negedge clk); clear_ex();
      checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== {a[31:2], 2'b00} ||
                    dmem_be_o !== b_t[i] || dmem_wdata_o !== w_t[i]) begin
        errors++; $display("FAIL store%0d_req got req=%b we=%b addr=%h be=%b wd=%h exp req=1 we=1 addr=%h be=%b wd=%h",
                           i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, {a[31:2], 2'b00}, b_t[i], w_t[i]);
      end
      dmem_gnt_i = 1'b1;
      @(negedge clk); dmem_gnt_i = 1'b0;
      e = sb.pop_front();
      checks++; if (valid_wb_o !== 1'b1 || rd_we_wb_o !== e.we || err_wb_o !== e.err || dmem_req_o !== 1'b0) begin
        errors++; $display("FAIL store%0d_wb got v=%b we=%b err=%b req=%b exp v=1 we=%b err=%b req=0",
                           i, valid_wb_o, rd_we_wb_o, err_wb_o, dmem_req_o, e.we, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    wb_exp_t e;
    drive_op(32'h104, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LW);
    sb.push_back('{32'hCAFE_F00D, 5'd9, 1'b1, 1'b0, 1'b1});
    @(negedge clk); clear_ex();
    for (int k = 0; k < 4; k++) begin
      checks++; if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h104 || dmem_be_o !== 4'b1111 || dmem_we_o !== 1'b0 || ready_ex_o !== 1'b0) begin
        errors++; $display("FAIL stall_req%0d got req=%b addr=%h be=%b we=%b rdy=%b exp req=1 addr=104 be=1111 we=0 rdy=0",
                           k, dmem_req_o, dmem_addr_o, dmem_be_o, dmem_we_o, ready_ex_o);
      end
      if (k < 3) @(negedge clk);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D; ready_wb_i = 1'b0;
    @(negedge clk); dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      checks++; if (valid_wb_o !== 1'b1 || rd_data_wb_o !== e.data || rd_addr_wb_o !== e.rd || rd_we_wb_o !== e.we ||
                    err_wb_o !== e.err || ready_ex_o !== 1'b0) begin
        errors++; $display("FAIL stall_wb%0d got v=%b d=%h rd=%0d we=%b err=%b rdy=%b exp d=%h rd=%0d we=%b err=%b rdy=0",
                           k, valid_wb_o, rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, err_wb_o, ready_ex_o, e.data, e.rd, e.we, e.err);
      end
      @(negedge clk);
    end
    ready_wb_i = 1'b1; #1;
    checks++; if (ready_ex_o !== 1'b1) begin errors++; $display("FAIL stall_release rdy got=%b exp=1", ready_ex_o); end
    @(negedge clk);
    checks++; if (valid_wb_o !== 1'b0) begin errors++; $display("FAIL stall_idle valid got=%b exp=0", valid_wb_o); end
  endtask

  task automatic test_back_to_back();
    wb_exp_t e;
    drive_op(32'hAAAA, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, F3_LW);
    sb.push_back('{32'hAAAA, 5'd1, 1'b1, 1'b0, 1'b1});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (valid_wb_o !== 1'b1 || rd_data_wb_o !== e.data || rd_addr_wb_o !== e.rd || rd_we_wb_o !== e.we) begin
        errors++; $display("FAIL b2b%0d_wb got v=%b d=%h rd=%0d we=%b exp d=%h rd=%0d we=%b",
                           k, valid_wb_o, rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, e.data, e.rd, e.we);
      end
      if (k == 0) begin
        drive_op(32'hBBBB, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, F3_LW);
        sb.push_back('{32'hBBBB, 5'd2, 1'b1, 1'b0, 1'b1});
      end else begin
        drive_op(32'h108, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, F3_LHU);
        sb.push_back('{32'h0000_1111, 5'd3, 1'b1, 1'b0, 1'b1});
      end
      #1;
      checks++; if (ready_ex_o !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got=%b exp=1", k, ready_ex_o); end
    end
    @(negedge clk); clear_ex();
    checks++; if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h108 || valid_wb_o !== 1'b0) begin
      errors++; $display("FAIL b2b_load_req got req=%b addr=%h v=%b exp req=1 addr=108 v=0", dmem_req_o, dmem_addr_o, valid_wb_o);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h2222_1111;
    @(negedge clk); dmem_rvalid_i = 1'b0;
    e = sb.pop_front();
    checks++; if (valid_wb_o !== 1'b1 || rd_data_wb_o !== e.data || rd_addr_wb_o !== e.rd || rd_we_wb_o !== e.we) begin
      errors++; $display("FAIL b2b_load_wb got v=%b d=%h rd=%0d we=%b exp d=%h rd=%0d we=%b",
                         valid_wb_o, rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, e.data, e.rd, e.we);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    wb_exp_t e;
    int n;
    // k=0: load that never gets rvalid; k=1: store that never gets gnt
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_op(32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, F3_LW);
      else        drive_op(32'h404, 32'h55, 5'd4, 1'b1, 1'b0, 1'b1, F3_SW);
      sb.push_back('{32'h0, 5'd0, 1'b0, 1'b1, 1'b0});
      @(negedge clk); clear_ex();
      if (k == 0) begin
        dmem_gnt_i = 1'b1;
        @(negedge clk); dmem_gnt_i = 1'b0;
      end
      n = 0;
      while (valid_wb_o !== 1'b1 && n < 400) begin
        n++; @(negedge clk);
      end
      checks++; if (n != 255) begin errors++; $display("FAIL timeout%0d_wait got=%0d cycles exp=255", k, n); end
      e = sb.pop_front();
      checks++; if (valid_wb_o !== 1'b1 || err_wb_o !== e.err || rd_we_wb_o !== e.we || dmem_req_o !== 1'b0) begin
        errors++; $display("FAIL timeout%0d_wb got v=%b err=%b we=%b req=%b exp v=1 err=1 we=0 req=0",
                           k, valid_wb_o, err_wb_o, rd_we_wb_o, dmem_req_o);
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      @(negedge clk); dmem_rvalid_i = 1'b0;
      checks++; if (valid_wb_o !== 1'b0 || ready_ex_o !== 1'b1) begin
        errors++; $display("FAIL timeout%0d_late_rvalid got v=%b rdy=%b exp v=0 rdy=1", k, valid_wb_o, ready_ex_o);
      end
    end
  endtask

  task automatic test_reset_mid_resp();
    drive_op(32'h500, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, F3_LW);
    @(negedge clk); clear_ex(); dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if ({ready_ex_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, valid_wb_o,
                  rd_data_wb_o, rd_addr_wb_o, rd_we_wb_o, err_wb_o} !== '0) begin
      errors++; $display("FAIL rst_mid_resp_outputs nonzero req=%b valid=%b ready=%b addr=%h", dmem_req_o, valid_wb_o, ready_ex_o, dmem_addr_o);
    end
    @(negedge clk); rst_n = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(negedge clk); dmem_rvalid_i = 1'b0;
    checks++; if (ready_ex_o !== 1'b1 || valid_wb_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_resp_idle got rdy=%b v=%b req=%b exp rdy=1 v=0 req=0", ready_ex_o, valid_wb_o, dmem_req_o);
    end
    @(negedge clk);
    checks++; if (valid_wb_o !== 1'b0) begin errors++; $display("FAIL rst_mid_resp_nowb got v=%b exp=0", valid_wb_o); end
  endtask

`ifdef CP_MEM_MISALIGN_EN
  task automatic test_misalign();
    wb_exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_op(32'h101, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, F3_LW);
      else        drive_op(32'h203, 32'h99, 5'd6, 1'b1, 1'b0, 1'b1, F3_SH);
      sb.push_back('{32'h0, 5'd0, 1'b0, 1'b1, 1'b0});
      @(negedge clk); clear_ex();
      e = sb.pop_front();
      checks++; if (dmem_req_o !== 1'b0 || valid_wb_o !== 1'b1 || err_wb_o !== e.err || rd_we_wb_o !== e.we) begin
        errors++; $display("FAIL misalign%0d got req=%b v=%b err=%b we=%b exp req=0 v=1 err=1 we=0",
                           k, dmem_req_o, valid_wb_o, err_wb_o, rd_we_wb_o);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_resp();
`ifdef CP_MEM_MISALIGN_EN
    test_misalign();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp_mem_stage.md
CP_MEM_STAGE -- requirements
Module: cp_mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum cycles spent waiting for dmem_gnt_i or dmem_rvalid_i before an access is aborted.
REQ-002 SHALL use one clock and an asynchronous, active-low reset; ports are:
 clk  in  1  clock, all state updates on the rising edge
 rst_n  in  1  asynchronous active-low reset
 valid_ex_i  in  1  EX result valid
 ready_ex_o  out  1  MEM accepts an EX result
 alu_rs_ex_i  in  32  ALU result or load/store byte address
 rs2_data_ex_i  in  32  store data
 rd_addr_ex_i  in  5  destination register
 rd_we_ex_i  in  1  register write enable
 dmem_re_ex_i  in  1  load operation
 dmem_we_ex_i  in  1  store operation
 func3_ex_i  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
 dmem_req_o  out  1  bus request
 dmem_we_o  out  1  bus write
 dmem_addr_o  out  32  word-aligned bus address
 dmem_be_o  out  4  byte enables
 dmem_wdata_o  out  32  lane-replicated write data
 dmem_gnt_i  in  1  request accepted
 dmem_rvalid_i  in  1  read data valid
 dmem_rdata_i  in  32  read data
 valid_wb_o  out  1  WB result valid
 ready_wb_i  in  1  WB accepts the result
 rd_data_wb_o  out  32  writeback data
 rd_addr_wb_o  out  5  destination register
 rd_we_wb_o  out  1  writeback enable
 err_wb_o  out  1  access fault (timeout or misaligned)

Function
REQ-003 SHALL implement the states IDLE, REQ, RESP and OUT.
REQ-004 ready_ex_o SHALL be 1 in IDLE, and in OUT when ready_wb_i=1; it SHALL be 0 otherwise.
REQ-005 Non-memory op accepted: SHALL latch alu_rs_ex_i as rd_data_wb_o and go to OUT, giving valid_wb_o one cycle after the accepting edge.
REQ-006 Load or store accepted: SHALL go to REQ, with dmem_req_o=1 and the address, be and wdata held stable until dmem_gnt_i=1.
REQ-007 REQ with gnt and a store: SHALL go to OUT with rd_we_wb_o=0 (no response wait); with gnt and a load: SHALL go to RESP.
REQ-008 RESP with rvalid: SHALL extract the addressed byte or halfword from dmem_rdata_i, sign-extend (LB/LH) or zero-extend (LBU/LHU), and go to OUT.
REQ-009 dmem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-010 dmem_be_o SHALL be 0001<<addr[1:0] for byte, 0011<<{addr[1],1'b0} for half, and 1111 for word.
REQ-011 dmem_wdata_o SHALL replicate the byte ×4 or the halfword ×2.
REQ-012 Timeout counter: SHALL clear on entering REQ and RESP and increment each waiting cycle; on reaching TIMEOUT_CYC it SHALL go to OUT with err_wb_o=1, rd_we_wb_o=0 and dmem_req_o dropped.
REQ-013 OUT: SHALL hold all WB outputs stable while ready_wb_i=0.
REQ-014 OUT with ready_wb_i=1 and valid_ex_i=1: SHALL accept the next op in the same cycle (back-to-back, no bubble).
REQ-015 OUT with ready_wb_i=1 and valid_ex_i=0: SHALL go to IDLE with valid_wb_o=0.
REQ-016 An op with both dmem_re_ex_i and dmem_we_ex_i set SHALL be treated as a store.
REQ-017 Late rvalid after a timeout SHALL be ignored.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, the counter to 0, and all outputs to 0; ready_ex_o becomes 1 after the first clock edge with rst_n high.
REQ-019 Reset during REQ or RESP SHALL abandon the access, with no WB result produced.

Configuration
REQ-020 With CP_MEM_MISALIGN_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL skip the bus and go directly to OUT with err_wb_o=1 and rd_we_wb_o=0.
REQ-021 Without CP_MEM_MISALIGN_EN, offending low address bits SHALL be masked (halfword uses addr[1], word uses offset 0) and err_wb_o SHALL only signal timeout.

Structure
REQ-022 Package cp_pkg SHALL hold the F3_LB/LH/LW/LBU/LHU/SB/SH/SW constants and the mem_state_e enum typedef.
REQ-023 The combinational sub-module cp_lsu_align SHALL compute be, wdata and load extraction.

Verification
REQ-024 Non-memory op: alu=0x1234, rd=5 -> valid_wb_o the next cycle, rd_data=0x1234, rd_we=1, no dmem_req_o.
REQ-025 LB at 0x103, rdata=0x80FF_FF00 -> addr 0x100, be=1111 on read, rd_data=0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-026 SH at 0x202, data 0xABCD -> addr 0x200, be=1100, wdata=0xABCD_ABCD, dmem_we_o=1, rd_we_wb_o=0.
REQ-027 Load with gnt withheld for 3 cycles and ready_wb_i low for 2 cycles -> request and WB outputs held stable; back-to-back ops then accepted with no bubble.
REQ-028 No rvalid for 255 cycles -> err_wb_o=1, rd_we_wb_o=0; rst_n pulsed mid-RESP -> all outputs 0, state IDLE.
REQ-029 With CP_MEM_MISALIGN_EN, LW at 0x101 -> no dmem_req_o, err_wb_o=1 the next cycle.
